// File: rtl/ras_predecode.sv
// Fetch-side predecoder feeding the return address stack: classifies RV32I
// control flow, drives ras push/pop, predicts targets and registers the beat toward decode.
package bmm_pkg;
  typedef struct packed {
    logic        vld;
    logic [31:0] ras_data;
  } ras_t;
endpackage

module ras_predecode #(
  parameter int unsigned SQUASH_BEATS = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        in_pc_i,
  input  logic [31:0]        in_instr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        out_pc_o,
  output logic [31:0]        out_instr_o,
  output logic               out_pred_taken_o,
  output logic [31:0]        out_pred_target_o,
  output logic               pred_redir_o,
  output logic [31:0]        pred_target_o,
  output logic               ras_push_o,
  output logic               ras_pop_o,
  output logic [31:0]        ras_pc_o,
  output logic               ras_flush_o,
  input  bmm_pkg::ras_t      ras_top_i,
  output logic [CNT_W-1:0]   cnt_call_o,
  output logic [CNT_W-1:0]   cnt_ret_o,
  output logic [CNT_W-1:0]   cnt_ret_miss_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned SQ_W = 2;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  logic [SQ_W-1:0] squash_cnt;
  logic            acc, live;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1;
  logic            link_rd, link_rs1;
  logic            is_jal, is_jalr, is_br, is_call, is_ret, is_pop;
  logic [XLEN-1:0] imm_j, imm_b, pc_plus4;
  logic            pred_taken;
  logic [XLEN-1:0] pred_tgt;
  logic            ret_miss;

  assign in_ready_o = ~flush_i & (~out_valid_o | out_ready_i);
  assign acc        = in_valid_i & in_ready_o;
  assign live       = acc & (squash_cnt == '0);

  assign opcode   = in_instr_i[6:0];
  assign rd       = in_instr_i[11:7];
  assign rs1      = in_instr_i[19:15];
  assign link_rd  = (rd == 5'd1) | (rd == 5'd5);
  assign link_rs1 = (rs1 == 5'd1) | (rs1 == 5'd5);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_br    = (opcode == OP_BRANCH);
  assign is_call  = (is_jal | is_jalr) & link_rd;
  assign is_ret   = is_jalr & link_rs1 & ~link_rd;
  // Linked rd and rs1 that differ: coroutine swap, pop then push.
  assign is_pop   = is_jalr & link_rs1 & (~link_rd | (rd != rs1));

  assign imm_j    = {{12{in_instr_i[31]}}, in_instr_i[19:12], in_instr_i[20], in_instr_i[30:21], 1'b0};
  assign imm_b    = {{20{in_instr_i[31]}}, in_instr_i[7], in_instr_i[30:25], in_instr_i[11:8], 1'b0};
  assign pc_plus4 = in_pc_i + 32'd4;

  assign ras_push_o  = live & ~flush_i & is_call;
  assign ras_pop_o   = live & ~flush_i & is_pop;
  assign ras_pc_o    = pc_plus4;
  assign ras_flush_o = flush_i;

  // Target prediction for the current input beat.
  always_comb begin
    pred_taken = 1'b0;
    pred_tgt   = pc_plus4;
    ret_miss   = 1'b0;
    if (is_jal) begin
      pred_taken = 1'b1;
      pred_tgt   = in_pc_i + imm_j;
    end else if (is_br && imm_b[XLEN-1]) begin
      pred_taken = 1'b1;
      pred_tgt   = in_pc_i + imm_b;
    end else if (is_ret) begin
      if (ras_top_i.vld) begin
        pred_taken = 1'b1;
        pred_tgt   = ras_top_i.ras_data;
      end else begin
        ret_miss = 1'b1;
      end
    end
  end

  // Output stage, redirect pulse and squash window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o       <= 1'b0;
      out_pc_o          <= '0;
      out_instr_o       <= '0;
      out_pred_taken_o  <= 1'b0;
      out_pred_target_o <= '0;
      pred_redir_o      <= 1'b0;
      pred_target_o     <= '0;
      squash_cnt        <= '0;
    end else if (flush_i) begin
      out_valid_o  <= 1'b0;
      pred_redir_o <= 1'b0;
      squash_cnt   <= '0;
    end else begin
      pred_redir_o <= live & pred_taken;
      if (live) begin
        out_valid_o       <= 1'b1;
        out_pc_o          <= in_pc_i;
        out_instr_o       <= in_instr_i;
        out_pred_taken_o  <= pred_taken;
        out_pred_target_o <= pred_tgt;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      if (live && pred_taken) begin
        pred_target_o <= pred_tgt;
        squash_cnt    <= SQ_W'(SQUASH_BEATS);
      end else if (acc && squash_cnt != '0) begin
        squash_cnt <= squash_cnt - SQ_W'(1);
      end
    end
  end

  // Saturating event counters; not cleared by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_call_o     <= '0;
      cnt_ret_o      <= '0;
      cnt_ret_miss_o <= '0;
    end else begin
      if (ras_push_o && cnt_call_o != '1)               cnt_call_o     <= cnt_call_o + CNT_W'(1);
      if (ras_pop_o && cnt_ret_o != '1)                 cnt_ret_o      <= cnt_ret_o + CNT_W'(1);
      if (live && ret_miss && cnt_ret_miss_o != '1)     cnt_ret_miss_o <= cnt_ret_miss_o + CNT_W'(1);
    end
  end

endmodule
